softmax_latency_responder: RTL and testbench
============================================

Name: softmax_latency_responder

Overview:
- Responder side of the softmax control handshake: a bank of four latency counters (expo, acc, reci, multi) plus two RAM address generators (input RAM read side, exponent RAM read side).
- Each counter takes a level enable from the control FSM and returns a done strobe once that stage's fixed pipeline latency has elapsed.
- Each address generator advances one element per enable cycle and reports the address and a last-element flag back to the FSM.
- Sits between the control FSM and the datapath IP cores (exp, accumulator, reciprocal, multiplier).

Parameters:
- TOTAL_VALUES, 1024, number of softmax elements per vector; address range 0..TOTAL_VALUES-1.
- ADDR_W, 10, address width; must satisfy 2^ADDR_W >= TOTAL_VALUES.
- EXPO_LAT, 18, exponent core latency in cycles (>=1).
- ACC_LAT, 12, accumulator latency in cycles (>=1).
- RECI_LAT, 28, reciprocal core latency in cycles (>=1).
- MULTI_LAT, 8, multiplier latency in cycles (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- expo_latency_cnt_en  in  1  exponent latency window active.
- expo_latency_cnt_done  out  1  exponent latency elapsed.
- acc_latency_cnt_en  in  1  accumulate window active.
- acc_latency_cnt_done  out  1  accumulate latency elapsed.
- reci_latency_cnt_en  in  1  reciprocal window active.
- reci_latency_cnt_done  out  1  reciprocal latency elapsed.
- multi_latency_cnt_en  in  1  multiply window active.
- multi_latency_cnt_done  out  1  multiply latency elapsed.
- addr_gen1_en  in  1  advance input-RAM read address.
- ram1_addr  out  ADDR_W  input-RAM port-B read address.
- ram1_last  out  1  last issued ram1 address was TOTAL_VALUES-1.
- addr_gen2_en  in  1  advance exponent-RAM read address.
- ram2_addr  out  ADDR_W  exponent-RAM port-B read address.
- ram2_last  out  1  last issued ram2 address was TOTAL_VALUES-1.

Behaviour:
- Reset (rst low, asynchronous): all counters 0, all done outputs 0, ram1_addr and ram2_addr 0, ram1_last and ram2_last 0.
- Counter channel (identical per channel, latency L):
  - Idle (en=0): count forced to 0 each cycle; done=0.
  - Counting (en=1, count<L-1): count increments each cycle.
  - Done: done = en AND (count==L-1), combinational from the count register. It asserts in the L-th consecutive en-high cycle, so the FSM leaves the state after exactly L cycles.
  - On the done cycle, count clears to 0 at the clock edge, so a held en gives one done pulse every L cycles.
  - en dropping mid-count: count aborts to 0; no done; no carry-over into the next window.
  - L=1: done is high in every en-high cycle.
  - Channels are fully independent; simultaneous enables are legal.
- Address generator (identical for gen1/gen2):
  - ram_addr is registered and presents the address for the current enable cycle.
  - On an edge with en=1: ram_addr <= (ram_addr==TOTAL_VALUES-1) ? 0 : ram_addr+1, and ram_last <= (ram_addr==TOTAL_VALUES-1).
  - With en=0, addr and last hold.
  - ram_last stays high until the next en cycle.
  - After address TOTAL_VALUES-1 is issued, ram_addr=0 and ram_last=1, and the FSM ends the pass on ram_last.
  - The next en cycle issues address 0 and clears ram_last, so no extra reset is needed between vectors.
- Asynchronous reset mid-pass returns all outputs to the reset values immediately.
- Counter width per channel is clog2(L+1); increments never wrap.

Decomposition:
- Shared package softmax_pkg holds TOTAL_VALUES, ADDR_W, the four latency constants, and the clog2 width function.
- One sub-module, latency_counter (parameter LAT; ports clk, rst, en, done), is instantiated four times.
- The address generator is small and stays inline as two always blocks.

Test Plan:
- EXPO_LAT=18: hold expo en high 18 cycles -> done low cycles 1–17, high exactly on cycle 18, count 0 afterwards; hold 36 cycles -> done pulses on cycles 18 and 36.
- Drop reci en after 10 cycles, re-raise -> no done; done arrives 28 cycles after the re-raise.
- L=1 build (MULTI_LAT=1): multi en high 3 cycles -> done high all 3 cycles.
- TOTAL_VALUES=8: 8 single-cycle addr_gen1_en pulses -> ram1_addr issues 0..7; after the 8th, ram1_addr=0 and ram1_last=1; 9th pulse -> addr 0, then 1, ram1_last=0.
- Raise all four enables and both addr_gen enables together -> each done fires at its own latency (8, 12, 18, 28); addresses advance independently.
- Assert rst low mid-count (acc count=5, ram2_addr=3) -> all done 0, addresses 0, last flags 0 immediately; a fresh acc window then takes a full 12 cycles.

Source files
------------

// File: rtl/softmax_pkg.sv
// Shared constants for the softmax responder: vector length, address width, stage latencies.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package softmax_pkg;

  localparam int TOTAL_VALUES = 1024;
  localparam int ADDR_W       = 10;
  localparam int EXPO_LAT     = 18;
  localparam int ACC_LAT      = 12;
  localparam int RECI_LAT     = 28;
  localparam int MULTI_LAT    = 8;

  // Bits needed to hold a count of 0..lat without wrapping.
  function automatic int cnt_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/latency_counter.sv
// Counts consecutive enable cycles and strobes done on the LAT-th one.
// Latency: done is combinational from the count register, high in the LAT-th en-high cycle.
// Backpressure: none; dropping en aborts the window and clears the count.
module latency_counter
  import softmax_pkg::*;
#(
  parameter int LAT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic done
);

  localparam int CW = cnt_width(LAT);
  localparam logic [CW-1:0] LAST_CNT = CW'(LAT - 1);

  logic [CW-1:0] count;

  // With LAT=1 LAST_CNT is 0, so done follows en every cycle.
  assign done = en && (count == LAST_CNT);

  // Count while enabled; restart on done so a held enable yields one pulse per LAT cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (!en || done) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/softmax_latency_responder.sv
// Responder for the softmax control FSM: four stage latency counters and two RAM read address generators.
// Latency: done strobes in the L-th en-high cycle; addresses advance one per enable cycle, registered.
// Backpressure: none; the FSM paces everything through level enables.
module softmax_latency_responder
  import softmax_pkg::*;
#(
  parameter int TOTAL_VALUES_P = TOTAL_VALUES,
  parameter int ADDR_W_P       = ADDR_W,
  parameter int EXPO_LAT_P     = EXPO_LAT,
  parameter int ACC_LAT_P      = ACC_LAT,
  parameter int RECI_LAT_P     = RECI_LAT,
  parameter int MULTI_LAT_P    = MULTI_LAT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                expo_latency_cnt_en,
  output logic                expo_latency_cnt_done,
  input  logic                acc_latency_cnt_en,
  output logic                acc_latency_cnt_done,
  input  logic                reci_latency_cnt_en,
  output logic                reci_latency_cnt_done,
  input  logic                multi_latency_cnt_en,
  output logic                multi_latency_cnt_done,
  input  logic                addr_gen1_en,
  output logic [ADDR_W_P-1:0] ram1_addr,
  output logic                ram1_last,
  input  logic                addr_gen2_en,
  output logic [ADDR_W_P-1:0] ram2_addr,
  output logic                ram2_last
);

  localparam logic [ADDR_W_P-1:0] LAST_ADDR = ADDR_W_P'(TOTAL_VALUES_P - 1);

  latency_counter #(.LAT(EXPO_LAT_P)) u_expo_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (expo_latency_cnt_en),
    .done (expo_latency_cnt_done)
  );

  latency_counter #(.LAT(ACC_LAT_P)) u_acc_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (acc_latency_cnt_en),
    .done (acc_latency_cnt_done)
  );

  latency_counter #(.LAT(RECI_LAT_P)) u_reci_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (reci_latency_cnt_en),
    .done (reci_latency_cnt_done)
  );

  latency_counter #(.LAT(MULTI_LAT_P)) u_multi_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (multi_latency_cnt_en),
    .done (multi_latency_cnt_done)
  );

  // Input-RAM read address: wrap after the last element and flag it until the next pass starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram1_addr <= '0;
      ram1_last <= 1'b0;
    end else if (addr_gen1_en) begin
      ram1_addr <= (ram1_addr == LAST_ADDR) ? '0 : ram1_addr + 1'b1;
      ram1_last <= (ram1_addr == LAST_ADDR);
    end
  end

  // Exponent-RAM read address: same scheme, advanced independently of the input RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram2_addr <= '0;
      ram2_last <= 1'b0;
    end else if (addr_gen2_en) begin
      ram2_addr <= (ram2_addr == LAST_ADDR) ? '0 : ram2_addr + 1'b1;
      ram2_last <= (ram2_addr == LAST_ADDR);
    end
  end

endmodule

// File: tb/tb_softmax_latency_responder.sv
// Scoreboard bench for softmax_latency_responder: expected done cycles and addresses queued by stimulus,
// popped and compared by a negedge monitor whenever a done strobe or an address-enable cycle appears.
// Main instance uses TOTAL_VALUES=8 with default latencies; a second instance checks MULTI_LAT=1.
module tb_softmax_latency_responder;

  localparam int TV = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       expo_en = 1'b0, acc_en = 1'b0, reci_en = 1'b0, multi_en = 1'b0;
  logic       g1_en = 1'b0, g2_en = 1'b0;
  logic       expo_done, acc_done, reci_done, multi_done;
  logic [9:0] ram1_addr, ram2_addr;
  logic       ram1_last, ram2_last;

  logic       l1_en = 1'b0;
  logic       l1_expo_done, l1_acc_done, l1_reci_done, l1_multi_done;
  logic [9:0] l1_ram1_addr, l1_ram2_addr;
  logic       l1_ram1_last, l1_ram2_last;

  softmax_latency_responder #(.TOTAL_VALUES_P(TV)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .expo_latency_cnt_en    (expo_en),
    .expo_latency_cnt_done  (expo_done),
    .acc_latency_cnt_en     (acc_en),
    .acc_latency_cnt_done   (acc_done),
    .reci_latency_cnt_en    (reci_en),
    .reci_latency_cnt_done  (reci_done),
    .multi_latency_cnt_en   (multi_en),
    .multi_latency_cnt_done (multi_done),
    .addr_gen1_en           (g1_en),
    .ram1_addr              (ram1_addr),
    .ram1_last              (ram1_last),
    .addr_gen2_en           (g2_en),
    .ram2_addr              (ram2_addr),
    .ram2_last              (ram2_last)
  );

  softmax_latency_responder #(.TOTAL_VALUES_P(TV), .MULTI_LAT_P(1)) dut_l1 (
    .clk                    (clk),
    .rst                    (rst),
    .expo_latency_cnt_en    (1'b0),
    .expo_latency_cnt_done  (l1_expo_done),
    .acc_latency_cnt_en     (1'b0),
    .acc_latency_cnt_done   (l1_acc_done),
    .reci_latency_cnt_en    (1'b0),
    .reci_latency_cnt_done  (l1_reci_done),
    .multi_latency_cnt_en   (l1_en),
    .multi_latency_cnt_done (l1_multi_done),
    .addr_gen1_en           (1'b0),
    .ram1_addr              (l1_ram1_addr),
    .ram1_last              (l1_ram1_last),
    .addr_gen2_en           (1'b0),
    .ram2_addr              (l1_ram2_addr),
    .ram2_last              (l1_ram2_last)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Channel index: 0 expo, 1 acc, 2 reci, 3 multi, 4 multi on the L=1 instance.
  int q_done[5][$];
  int q_a1[$];
  int q_a2[$];
  int a1 = 0;
  int a2 = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every done strobe must match the next expected cycle; every enable cycle the next address.
  always @(negedge clk) begin
    logic [4:0] d;
    int e;
    d = {l1_multi_done, multi_done, reci_done, acc_done, expo_done};
    for (int c = 0; c < 5; c++) begin
      if (d[c]) begin
        if (q_done[c].size() == 0) begin
          check($sformatf("unexpected_done_ch%0d_cycle", c), cyc, -1);
        end else begin
          e = q_done[c].pop_front();
          check($sformatf("done_ch%0d_cycle", c), cyc, e);
        end
      end
    end
    if (g1_en && rst) begin
      if (q_a1.size() == 0) check("unexpected_ram1_issue", int'(ram1_addr), -1);
      else begin
        e = q_a1.pop_front();
        check("ram1_addr_issue", int'(ram1_addr), e);
      end
    end
    if (g2_en && rst) begin
      if (q_a2.size() == 0) check("unexpected_ram2_issue", int'(ram2_addr), -1);
      else begin
        e = q_a2.pop_front();
        check("ram2_addr_issue", int'(ram2_addr), e);
      end
    end
  end

  initial begin
    int c0;
    int c1;

    // Reset state
    step(2);
    check("rst_expo_done", int'(expo_done), 0);
    check("rst_acc_done", int'(acc_done), 0);
    check("rst_reci_done", int'(reci_done), 0);
    check("rst_multi_done", int'(multi_done), 0);
    check("rst_ram1_addr", int'(ram1_addr), 0);
    check("rst_ram1_last", int'(ram1_last), 0);
    check("rst_ram2_addr", int'(ram2_addr), 0);
    check("rst_ram2_last", int'(ram2_last), 0);
    rst = 1'b1;
    step(2);

    // Expo window of exactly 18 cycles: one done, on cycle 18
    c0 = cyc;
    q_done[0].push_back(c0 + 17);
    expo_en = 1'b1;
    step(18);
    expo_en = 1'b0;
    step(2);

    // Expo held 36 cycles: done on cycles 18 and 36 (count restarted from 0)
    c0 = cyc;
    q_done[0].push_back(c0 + 17);
    q_done[0].push_back(c0 + 35);
    expo_en = 1'b1;
    step(36);
    expo_en = 1'b0;
    step(2);

    // Reci aborted after 10 cycles, then a fresh 28-cycle window
    reci_en = 1'b1;
    step(10);
    reci_en = 1'b0;
    step(1);
    c1 = cyc;
    q_done[2].push_back(c1 + 27);
    reci_en = 1'b1;
    step(28);
    reci_en = 1'b0;
    step(2);

    // L=1 multiplier: done in every enabled cycle
    c0 = cyc;
    q_done[4].push_back(c0);
    q_done[4].push_back(c0 + 1);
    q_done[4].push_back(c0 + 2);
    l1_en = 1'b1;
    step(3);
    l1_en = 1'b0;
    step(2);

    // Eight single-cycle gen1 pulses issue 0..7, then wrap with last flagged
    for (int i = 0; i < TV; i++) begin
      q_a1.push_back(i);
      g1_en = 1'b1;
      step(1);
      g1_en = 1'b0;
      step(1);
      if (i == TV - 2) check("ram1_last_before_end", int'(ram1_last), 0);
    end
    check("ram1_addr_after_pass", int'(ram1_addr), 0);
    check("ram1_last_after_pass", int'(ram1_last), 1);
    q_a1.push_back(0);
    g1_en = 1'b1;
    step(1);
    g1_en = 1'b0;
    step(1);
    check("ram1_addr_next_pass", int'(ram1_addr), 1);
    check("ram1_last_next_pass", int'(ram1_last), 0);
    a1 = 1;

    // All channels and both generators together for 28 cycles
    c0 = cyc;
    q_done[0].push_back(c0 + 17);
    q_done[1].push_back(c0 + 11);
    q_done[1].push_back(c0 + 23);
    q_done[2].push_back(c0 + 27);
    q_done[3].push_back(c0 + 7);
    q_done[3].push_back(c0 + 15);
    q_done[3].push_back(c0 + 23);
    for (int i = 0; i < 28; i++) begin
      q_a1.push_back(a1);
      a1 = (a1 + 1) % TV;
      q_a2.push_back(a2);
      a2 = (a2 + 1) % TV;
    end
    expo_en = 1'b1; acc_en = 1'b1; reci_en = 1'b1; multi_en = 1'b1;
    g1_en = 1'b1; g2_en = 1'b1;
    step(28);
    expo_en = 1'b0; acc_en = 1'b0; reci_en = 1'b0; multi_en = 1'b0;
    g1_en = 1'b0; g2_en = 1'b0;
    step(2);
    check("ram1_addr_after_concurrent", int'(ram1_addr), 5);
    check("ram2_addr_after_concurrent", int'(ram2_addr), 4);

    // Bring ram2 to address 3, acc count to 5, then reset asynchronously mid-cycle
    while (a2 != 3) begin
      q_a2.push_back(a2);
      a2 = (a2 + 1) % TV;
      g2_en = 1'b1;
      step(1);
      g2_en = 1'b0;
    end
    check("ram2_addr_pre_reset", int'(ram2_addr), 3);
    acc_en = 1'b1;
    step(5);
    rst = 1'b0;
    #1;
    check("async_rst_acc_done", int'(acc_done), 0);
    check("async_rst_ram1_addr", int'(ram1_addr), 0);
    check("async_rst_ram1_last", int'(ram1_last), 0);
    check("async_rst_ram2_addr", int'(ram2_addr), 0);
    check("async_rst_ram2_last", int'(ram2_last), 0);
    acc_en = 1'b0;
    step(1);
    rst = 1'b1;
    a1 = 0;
    a2 = 0;
    step(1);

    // Fresh acc window after reset takes the full 12 cycles; ram1 restarts at 0
    c0 = cyc;
    q_done[1].push_back(c0 + 11);
    q_a1.push_back(0);
    acc_en = 1'b1;
    g1_en = 1'b1;
    step(1);
    g1_en = 1'b0;
    step(11);
    acc_en = 1'b0;
    step(3);

    // Every queued expectation must have been consumed
    for (int c = 0; c < 5; c++) check($sformatf("pending_done_ch%0d", c), q_done[c].size(), 0);
    check("pending_ram1", q_a1.size(), 0);
    check("pending_ram2", q_a2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
